// File: rtl/store_buffer_core.sv
// store_buffer_core: circular store buffer between the memory stage and the
// data cache. Stores wait here until the ROB commits them, then drain to the
// cache in program order. Loads can query the buffer for aliasing and
// forwarding.
// Optional feature macro: STORE_BUFFER_BYPASS_EN enables load data forwarding.
// Without it, only aliasing detection (bypass_needed) is reported.

`ifndef STORE_BUFFER_ENTRIES
`define STORE_BUFFER_ENTRIES 4
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 3
`endif
`ifndef SIZE_WRITE_WIDTH
`define SIZE_WRITE_WIDTH 2
`endif
`ifndef BYTE_SIZE
`define BYTE_SIZE 1
`endif
`ifndef FULL_WORD_SIZE
`define FULL_WORD_SIZE 2
`endif

module store_buffer_core #(
  parameter int          N                = `STORE_BUFFER_ENTRIES,
  parameter int          WORD_SIZE        = `WORD_SIZE,
  parameter int          WIDTH            = `ADDRESS_WIDTH,
  parameter int          ROB_ENTRY_WIDTH  = `ROB_ENTRY_WIDTH,
  parameter int          SIZE_WRITE_WIDTH = `SIZE_WRITE_WIDTH,
  parameter int unsigned INIT             = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WORD_SIZE-1:0]        store_value,
  input  logic [WIDTH-1:0]            physical_address,
  input  logic [ROB_ENTRY_WIDTH-1:0]  input_rob_id,
  input  logic [SIZE_WRITE_WIDTH-1:0] op_size,
  input  logic                        store,
  input  logic                        store_success,
  input  logic                        TLBexception,
  input  logic                        store_permission,
  input  logic [ROB_ENTRY_WIDTH-1:0]  store_permission_rob_id,
  output logic [WORD_SIZE-1:0]        cache_store_value,
  output logic [WIDTH-1:0]            cache_physical_address,
  output logic                        cache_wenable,
  output logic [SIZE_WRITE_WIDTH-1:0] cache_store_size,
  output logic                        full,
  output logic [WORD_SIZE-1:0]        bypass_value,
  output logic                        bypass_needed,
  output logic                        bypass_possible
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [WORD_SIZE-1:0]        value              [N];
  logic [WIDTH-1:0]            physical_addresses [N];
  logic [SIZE_WRITE_WIDTH-1:0] size               [N];
  logic [ROB_ENTRY_WIDTH-1:0]  rob_id             [N];
  logic [N-1:0]                valid;
  logic [N-1:0]                can_store;

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic alloc;
  logic drain;
  logic hit;

  // Head entry is always presented to the cache; it writes only once committed.
  assign full                   = (count == CNT_W'(N));
  assign cache_wenable          = valid[head] & can_store[head];
  assign cache_store_value      = value[head];
  assign cache_physical_address = physical_addresses[head];
  assign cache_store_size       = size[head];
  assign alloc                  = store & ~TLBexception & ~full;
  assign drain                  = cache_wenable & store_success;

`ifdef STORE_BUFFER_BYPASS_EN
  logic [PTR_W-1:0] sel;

  // Keep only the bytes a load of size sz would read, zero-extended.
  function automatic logic [WORD_SIZE-1:0] mask_to_size(
    input logic [WORD_SIZE-1:0]        v,
    input logic [SIZE_WRITE_WIDTH-1:0] sz
  );
    if (sz == SIZE_WRITE_WIDTH'(`BYTE_SIZE)) begin
      return {{(WORD_SIZE-8){1'b0}}, v[7:0]};
    end
    return v;
  endfunction
`endif

  // Word-granular alias search, oldest to youngest so the youngest match wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    hit = 1'b0;
    idx = '0;
`ifdef STORE_BUFFER_BYPASS_EN
    sel = '0;
`endif
    for (int i = 0; i < N; i++) begin
      idx = head + PTR_W'(i);
      if (valid[idx] &&
          physical_addresses[idx][WIDTH-1:2] == physical_address[WIDTH-1:2]) begin
        hit = 1'b1;
`ifdef STORE_BUFFER_BYPASS_EN
        sel = idx;
`endif
      end
    end
  end

  assign bypass_needed = ~store & hit;

`ifdef STORE_BUFFER_BYPASS_EN
  // Forward only when the youngest alias covers the load exactly.
  always_comb begin
    bypass_possible = ~store & hit &
                      (physical_addresses[sel] == physical_address) &
                      (size[sel] >= op_size);
    bypass_value    = bypass_possible ? mask_to_size(value[sel], op_size) : '0;
  end
`else
  logic unused_lookup_bits;
  assign unused_lookup_bits = &{1'b0, physical_address[1:0], op_size};
  assign bypass_possible    = 1'b0;
  assign bypass_value       = '0;
`endif

  // Entry state, pointers and occupancy: commit, drain and allocate.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
      can_store <= '0;
      for (int i = 0; i < N; i++) begin
        value[i]              <= WORD_SIZE'(INIT);
        physical_addresses[i] <= WIDTH'(INIT);
        size[i]               <= SIZE_WRITE_WIDTH'(INIT);
        rob_id[i]             <= ROB_ENTRY_WIDTH'(INIT);
      end
    end else begin
      if (store_permission) begin
        for (int i = 0; i < N; i++) begin
          if (valid[i] && rob_id[i] == store_permission_rob_id) begin
            can_store[i] <= 1'b1;
          end
        end
      end
      if (drain) begin
        value[head]              <= '0;
        physical_addresses[head] <= '0;
        size[head]               <= '0;
        rob_id[head]             <= '0;
        valid[head]              <= 1'b0;
        can_store[head]          <= 1'b0;
        head                     <= head + PTR_W'(1);
      end
      // Allocation is last so a same-cycle commit never marks the new entry.
      if (alloc) begin
        value[tail]              <= store_value;
        physical_addresses[tail] <= physical_address;
        size[tail]               <= op_size;
        rob_id[tail]             <= input_rob_id;
        valid[tail]              <= 1'b1;
        can_store[tail]          <= 1'b0;
        tail                     <= tail + PTR_W'(1);
      end
      case ({alloc, drain})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer_core.sv
// Testbench for store_buffer_core: directed vector table plus randomized
// traffic checked against a queue-based model of the store buffer.
module tb_store_buffer_core;

  localparam int N = 4;

`ifdef STORE_BUFFER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] store_value;
  logic [31:0] physical_address;
  logic [2:0]  input_rob_id;
  logic [1:0]  op_size;
  logic        store;
  logic        store_success;
  logic        TLBexception;
  logic        store_permission;
  logic [2:0]  store_permission_rob_id;
  logic [31:0] cache_store_value;
  logic [31:0] cache_physical_address;
  logic        cache_wenable;
  logic [1:0]  cache_store_size;
  logic        full;
  logic [31:0] bypass_value;
  logic        bypass_needed;
  logic        bypass_possible;

  always #5 clk = ~clk;

  store_buffer_core dut (
    .clk                     (clk),
    .rst                     (rst),
    .store_value             (store_value),
    .physical_address        (physical_address),
    .input_rob_id            (input_rob_id),
    .op_size                 (op_size),
    .store                   (store),
    .store_success           (store_success),
    .TLBexception            (TLBexception),
    .store_permission        (store_permission),
    .store_permission_rob_id (store_permission_rob_id),
    .cache_store_value       (cache_store_value),
    .cache_physical_address  (cache_physical_address),
    .cache_wenable           (cache_wenable),
    .cache_store_size        (cache_store_size),
    .full                    (full),
    .bypass_value            (bypass_value),
    .bypass_needed           (bypass_needed),
    .bypass_possible         (bypass_possible)
  );

  typedef struct {
    string       nm;
    logic        r, st;
    logic [31:0] val, addr;
    logic [2:0]  rob;
    logic [1:0]  sz;
    logic        tlb, pm;
    logic [2:0]  pid;
    logic        sc, ck;
    logic [31:0] ecv, eca;
    logic [1:0]  ecs;
    logic        ew, ef, ebn, ebp;
    logic [31:0] ebv;
  } vec_t;

  typedef struct {
    logic [31:0] v, a;
    logic [2:0]  r;
    logic [1:0]  s;
    bit          c;
  } ent_t;

  vec_t vecs[$];
  ent_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic r, input logic st,
                     input logic [31:0] val, input logic [31:0] addr,
                     input logic [2:0] rob, input logic [1:0] sz, input logic tlb,
                     input logic pm, input logic [2:0] pid, input logic sc,
                     input logic ck, input logic [31:0] ecv, input logic [31:0] eca,
                     input logic [1:0] ecs, input logic ew, input logic ef,
                     input logic ebn, input logic ebp, input logic [31:0] ebv);
    vec_t x;
    x.nm = nm; x.r = r; x.st = st; x.val = val; x.addr = addr; x.rob = rob;
    x.sz = sz; x.tlb = tlb; x.pm = pm; x.pid = pid; x.sc = sc; x.ck = ck;
    x.ecv = ecv; x.eca = eca; x.ecs = ecs; x.ew = ew; x.ef = ef;
    x.ebn = ebn; x.ebp = ebp; x.ebv = ebv;
    vecs.push_back(x);
  endtask

  task automatic drive(input logic r, input logic st, input logic [31:0] val,
                       input logic [31:0] addr, input logic [2:0] rob,
                       input logic [1:0] sz, input logic tlb, input logic pm,
                       input logic [2:0] pid, input logic sc);
    rst = r; store = st; store_value = val; physical_address = addr;
    input_rob_id = rob; op_size = sz; TLBexception = tlb;
    store_permission = pm; store_permission_rob_id = pid; store_success = sc;
  endtask

  task automatic check_all(input string p, input logic [31:0] ecv, input logic [31:0] eca,
                           input logic [1:0] ecs, input logic ew, input logic ef,
                           input logic ebn, input logic ebp, input logic [31:0] ebv);
    chk({p, ".cval"}, cache_store_value, ecv);
    chk({p, ".caddr"}, cache_physical_address, eca);
    chk({p, ".csize"}, 32'(cache_store_size), 32'(ecs));
    chk({p, ".wen"}, 32'(cache_wenable), 32'(ew));
    chk({p, ".full"}, 32'(full), 32'(ef));
    chk({p, ".bneed"}, 32'(bypass_needed), 32'(ebn));
    chk({p, ".bposs"}, 32'(bypass_possible), 32'(ebp));
    chk({p, ".bval"}, bypass_value, ebv);
  endtask

  // Apply one cycle of model update using the inputs currently driven.
  task automatic model_step();
    bit   do_alloc, do_drain;
    ent_t e;
    if (rst) begin
      q.delete();
      return;
    end
    do_alloc = store && !TLBexception && (q.size() < N);
    do_drain = (q.size() > 0) && q[0].c && store_success;
    if (store_permission)
      foreach (q[k]) if (q[k].r == store_permission_rob_id) q[k].c = 1'b1;
    if (do_drain) void'(q.pop_front());
    if (do_alloc) begin
      e.v = store_value; e.a = physical_address; e.r = input_rob_id;
      e.s = op_size; e.c = 1'b0;
      q.push_back(e);
    end
  endtask

  task automatic model_check(input int cyc);
    logic [31:0] ecv, eca, ebv;
    logic [1:0]  ecs;
    logic        ew, ef, ebn, ebp;
    int          m;
    bit          found;
    ecv = 0; eca = 0; ecs = 0; ew = 0; ebn = 0; ebp = 0; ebv = 0; m = 0; found = 0;
    if (q.size() > 0) begin
      ecv = q[0].v; eca = q[0].a; ecs = q[0].s; ew = q[0].c;
    end
    ef = (q.size() == N);
    if (!store) begin
      for (int k = q.size() - 1; k >= 0; k--)
        if (!found && q[k].a[31:2] == physical_address[31:2]) begin
          found = 1; m = k;
        end
      ebn = found;
      if (found && BYP && q[m].a == physical_address && q[m].s >= op_size) begin
        ebp = 1;
        ebv = (op_size == 2'd1) ? {24'h0, q[m].v[7:0]} : q[m].v;
      end
    end
    check_all($sformatf("rnd%0d", cyc), ecv, eca, ecs, ew, ef, ebn, ebp, ebv);
  endtask

  initial begin
    //   name            r st val           addr      rob sz tlb pm pid sc ck  ecv      eca      ecs ew ef bn bp   bv
    add("rst_state",     0, 0, 0,           0,        0,  2, 0,  0, 0,  0, 1, 0,       0,       0,  0, 0, 0, 0,   0);
    add("alloc0",        0, 1, 26,          4,        0,  2, 0,  0, 0,  0, 1, 0,       0,       0,  0, 0, 0, 0,   0);
    add("alloc1",        0, 1, 2,           8,        2,  1, 0,  0, 0,  0, 1, 26,      4,       2,  0, 0, 0, 0,   0);
    add("look4",         0, 0, 0,           4,        0,  2, 0,  0, 0,  0, 1, 26,      4,       2,  0, 0, 1, BYP, BYP ? 32'd26 : 32'd0);
    add("rst_store",     1, 1, 99,          20,       1,  2, 0,  0, 0,  0, 0, 0,       0,       0,  0, 0, 0, 0,   0);
    add("after_rst",     0, 0, 0,           4,        0,  2, 0,  0, 0,  0, 1, 0,       0,       0,  0, 0, 0, 0,   0);
    add("fill0",         0, 1, 'h11,        'h100,    0,  2, 0,  0, 0,  0, 1, 0,       0,       0,  0, 0, 0, 0,   0);
    add("fill1",         0, 1, 'h22,        'h104,    1,  2, 0,  0, 0,  0, 1, 'h11,    'h100,   2,  0, 0, 0, 0,   0);
    add("fill2",         0, 1, 'h33,        'h108,    2,  2, 0,  0, 0,  0, 1, 'h11,    'h100,   2,  0, 0, 0, 0,   0);
    add("fill3",         0, 1, 'h44,        'h10C,    3,  2, 0,  0, 0,  0, 1, 'h11,    'h100,   2,  0, 0, 0, 0,   0);
    add("fifth",         0, 1, 'h55,        'h110,    4,  2, 0,  0, 0,  0, 1, 'h11,    'h100,   2,  0, 1, 0, 0,   0);
    add("perm_rob2",     0, 0, 0,           'h200,    0,  2, 0,  1, 2,  0, 1, 'h11,    'h100,   2,  0, 1, 0, 0,   0);
    add("hold_inorder",  0, 0, 0,           'h200,    0,  2, 0,  0, 0,  1, 1, 'h11,    'h100,   2,  0, 1, 0, 0,   0);
    add("perm_rob0",     0, 0, 0,           'h200,    0,  2, 0,  1, 0,  0, 1, 'h11,    'h100,   2,  0, 1, 0, 0,   0);
    add("drain0",        0, 0, 0,           'h200,    0,  2, 0,  0, 0,  1, 1, 'h11,    'h100,   2,  1, 1, 0, 0,   0);
    add("after_drain",   0, 0, 0,           'h200,    0,  2, 0,  0, 0,  0, 1, 'h22,    'h104,   2,  0, 0, 0, 0,   0);
    add("fifth_absent",  0, 0, 0,           'h110,    0,  2, 0,  0, 0,  0, 1, 'h22,    'h104,   2,  0, 0, 0, 0,   0);
    add("perm_rob1",     0, 0, 0,           'h200,    0,  2, 0,  1, 1,  0, 1, 'h22,    'h104,   2,  0, 0, 0, 0,   0);
    add("drain1",        0, 0, 0,           'h200,    0,  2, 0,  0, 0,  1, 1, 'h22,    'h104,   2,  1, 0, 0, 0,   0);
    add("drain2",        0, 0, 0,           'h200,    0,  2, 0,  0, 0,  1, 1, 'h33,    'h108,   2,  1, 0, 0, 0,   0);
    add("alloc_word",    0, 1, 'hAABBCCDD,  12,       5,  2, 0,  0, 0,  0, 1, 'h44,    'h10C,   2,  0, 0, 0, 0,   0);
    add("ld12_byte",     0, 0, 0,           12,       0,  1, 0,  0, 0,  0, 1, 'h44,    'h10C,   2,  0, 0, 1, BYP, BYP ? 32'hDD : 32'd0);
    add("ld16_byte",     0, 0, 0,           16,       0,  1, 0,  0, 0,  0, 1, 'h44,    'h10C,   2,  0, 0, 0, 0,   0);
    add("ld13_byte",     0, 0, 0,           13,       0,  1, 0,  0, 0,  0, 1, 'h44,    'h10C,   2,  0, 0, 1, 0,   0);
    add("ld12_word",     0, 0, 0,           12,       0,  2, 0,  0, 0,  0, 1, 'h44,    'h10C,   2,  0, 0, 1, BYP, BYP ? 32'hAABBCCDD : 32'd0);
    add("alloc_byte",    0, 1, 'h12345678,  12,       6,  1, 0,  0, 0,  0, 1, 'h44,    'h10C,   2,  0, 0, 0, 0,   0);
    add("young_byte",    0, 0, 0,           12,       0,  1, 0,  0, 0,  0, 1, 'h44,    'h10C,   2,  0, 0, 1, BYP, BYP ? 32'h78 : 32'd0);
    add("young_word",    0, 0, 0,           12,       0,  2, 0,  0, 0,  0, 1, 'h44,    'h10C,   2,  0, 0, 1, 0,   0);
    add("tlb_fault",     0, 1, 'h999,       'h300,    7,  2, 1,  0, 0,  0, 1, 'h44,    'h10C,   2,  0, 0, 0, 0,   0);
    add("tlb_absent",    0, 0, 0,           'h300,    0,  2, 0,  0, 0,  0, 1, 'h44,    'h10C,   2,  0, 0, 0, 0,   0);

    drive(1, 0, 0, 0, 0, 2, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;

    // Directed table
    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].st, vecs[i].val, vecs[i].addr, vecs[i].rob,
            vecs[i].sz, vecs[i].tlb, vecs[i].pm, vecs[i].pid, vecs[i].sc);
      @(negedge clk);
      if (vecs[i].ck)
        check_all(vecs[i].nm, vecs[i].ecv, vecs[i].eca, vecs[i].ecs, vecs[i].ew,
                  vecs[i].ef, vecs[i].ebn, vecs[i].ebp, vecs[i].ebv);
      @(posedge clk);
      #1;
    end

    // Randomized traffic against the queue model
    drive(1, 0, 0, 0, 0, 2, 0, 0, 0, 0);
    @(posedge clk);
    model_step();
    #1;
    for (int c = 0; c < 800; c++) begin
      logic [2:0] pid;
      pid = 3'($urandom_range(0, 7));
      if (q.size() > 0 && $urandom_range(0, 1) == 1)
        pid = q[$urandom_range(0, q.size() - 1)].r;
      drive(($urandom_range(0, 99) == 0),
            1'($urandom_range(0, 1)),
            $urandom,
            32'h40 + 32'($urandom_range(0, 23)),
            3'($urandom_range(0, 7)),
            2'($urandom_range(1, 2)),
            ($urandom_range(0, 9) == 0),
            1'($urandom_range(0, 1)),
            pid,
            ($urandom_range(0, 3) != 0));
      @(negedge clk);
      if (!rst) model_check(c);
      @(posedge clk);
      model_step();
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
